// File: rtl/int_sequencer.sv
// int_sequencer: latches interrupt requests, waits for an instruction boundary and injects
// push/pop opcodes into the decode slot. Define INT_NEST_EN to allow nested entry up to MAX_NEST.
module int_sequencer #(
    parameter int N        = 5,
    parameter int NUM_INT  = 4,
    parameter int MAX_NEST = 3,
    localparam int IDXW    = (NUM_INT > 1) ? $clog2(NUM_INT) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_INT-1:0] int_req,
    input  logic [N-1:0]       fetched_op,
    input  logic               fetch_valid,
    input  logic               one_more_fetch,
    input  logic               stall,
    output logic               inject_valid,
    output logic [N-1:0]       inject_op,
    output logic               fetch_hold,
    output logic [NUM_INT-1:0] int_ack,
    output logic [IDXW-1:0]    vector_idx,
    output logic [2:0]         nest_cnt,
    output logic               busy
);

    localparam logic [N-1:0] OP_NOP    = '0;
    localparam logic [N-1:0] OP_PUSH_H = N'(5'b10110);
    localparam logic [N-1:0] OP_PUSH_L = N'(5'b10101);
    localparam logic [N-1:0] OP_PUSH_F = N'(5'b11111);
    localparam logic [N-1:0] OP_POP_L  = N'(5'b10111);
    localparam logic [N-1:0] OP_POP_F  = N'(5'b01111);
    localparam logic [N-1:0] OP_RTI    = N'(5'b11110);

`ifdef INT_NEST_EN
    localparam logic [2:0] NEST_LIM = 3'(MAX_NEST);
`else
    // Single-level entry; a degenerate MAX_NEST of 0 still blocks entry entirely.
    localparam logic [2:0] NEST_LIM = (MAX_NEST < 1) ? 3'(MAX_NEST) : 3'd1;
`endif

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_BND = 3'd1,
        PUSH_H   = 3'd2,
        PUSH_L   = 3'd3,
        PUSH_F   = 3'd4,
        POP_L    = 3'd5,
        POP_F    = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_INT-1:0] pending_q, pending_d;
    logic [IDXW-1:0]    vec_q, vec_d;
    logic [2:0]         nest_q, nest_d;
    logic               wait_q, wait_d;

    logic [IDXW-1:0]    pend_idx;
    logic               pend_any;
    logic [NUM_INT-1:0] ack_vec;
    logic               eligible;
    logic               rti_seen;

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        pend_idx = '0;
        pend_any = 1'b0;
        for (int unsigned i = NUM_INT; i > 0; i--) begin
            if (pending_q[i-1]) begin
                pend_idx = IDXW'(i - 1);
                pend_any = 1'b1;
            end
        end
    end

    always_comb begin
        ack_vec = '0;
        for (int unsigned i = 0; i < NUM_INT; i++) begin
            ack_vec[i] = (state_q == PUSH_F) && !stall && (vec_q == IDXW'(i));
        end
    end

    assign eligible  = pend_any && (nest_q < NEST_LIM);
    assign rti_seen  = fetch_valid && (fetched_op == OP_RTI);
    assign pending_d = (pending_q | int_req) & ~ack_vec;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        vec_d   = vec_q;
        nest_d  = nest_q;
        if (!stall) begin
            case (state_q)
                IDLE: begin
                    if (rti_seen) begin
                        state_d = POP_L;
                    end else if (eligible) begin
                        state_d = WAIT_BND;
                        vec_d   = pend_idx;
                        wait_d  = one_more_fetch;
                    end
                end
                WAIT_BND: begin
                    if (wait_q) wait_d = 1'b0;
                    else        state_d = PUSH_H;
                end
                PUSH_H: state_d = PUSH_L;
                PUSH_L: state_d = PUSH_F;
                PUSH_F: begin
                    state_d = IDLE;
                    if (nest_q < NEST_LIM) nest_d = nest_q + 3'd1;
                end
                POP_L:  state_d = POP_F;
                POP_F: begin
                    state_d = IDLE;
                    if (nest_q != 3'd0) nest_d = nest_q - 3'd1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            vec_q     <= '0;
            nest_q    <= '0;
            wait_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            vec_q     <= vec_d;
            nest_q    <= nest_d;
            wait_q    <= wait_d;
        end
    end

    always_comb begin
        inject_valid = 1'b0;
        inject_op    = OP_NOP;
        fetch_hold   = 1'b0;
        case (state_q)
            WAIT_BND: fetch_hold = 1'b1;
            PUSH_H: begin
                inject_valid = 1'b1;
                inject_op    = OP_PUSH_H;
                fetch_hold   = 1'b1;
            end
            PUSH_L: begin
                inject_valid = 1'b1;
                inject_op    = OP_PUSH_L;
                fetch_hold   = 1'b1;
            end
            PUSH_F: begin
                inject_valid = 1'b1;
                inject_op    = OP_PUSH_F;
                fetch_hold   = 1'b1;
            end
            POP_L: begin
                inject_valid = 1'b1;
                inject_op    = OP_POP_L;
            end
            POP_F: begin
                inject_valid = 1'b1;
                inject_op    = OP_POP_F;
                fetch_hold   = 1'b1;
            end
            default: ;
        endcase
    end

    assign int_ack    = ack_vec;
    assign vector_idx = vec_q;
    assign nest_cnt   = nest_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_int_sequencer.sv
// Table-driven bench for int_sequencer: per-cycle stimulus with expected outputs for that cycle,
// queued on drive and compared on the falling edge.
module tb_int_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] int_req;
    logic [4:0] fetched_op;
    logic       fetch_valid;
    logic       one_more_fetch;
    logic       stall;
    logic       inject_valid;
    logic [4:0] inject_op;
    logic       fetch_hold;
    logic [3:0] int_ack;
    logic [1:0] vector_idx;
    logic [2:0] nest_cnt;
    logic       busy;

    always #5 clk = ~clk;

    int_sequencer #(.N(5), .NUM_INT(4), .MAX_NEST(2)) dut (
        .clk(clk), .reset_n(reset_n), .int_req(int_req), .fetched_op(fetched_op),
        .fetch_valid(fetch_valid), .one_more_fetch(one_more_fetch), .stall(stall),
        .inject_valid(inject_valid), .inject_op(inject_op), .fetch_hold(fetch_hold),
        .int_ack(int_ack), .vector_idx(vector_idx), .nest_cnt(nest_cnt), .busy(busy)
    );

    typedef enum int { S_IDLE, S_WT, S_PH, S_PL, S_PF, S_POPL, S_POPF } st_t;

    typedef struct {
        string      tag;
        logic       rst_n;
        logic [3:0] req;
        logic       fv;
        logic [4:0] op;
        logic       omf;
        logic       stl;
        logic       iv;
        logic [4:0] iop;
        logic       fh;
        logic [3:0] ack;
        logic [1:0] vidx;
        logic [2:0] nest;
        logic       busy;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic add(input string tag, input logic r, input logic [3:0] req, input logic rti,
                       input logic omf, input logic stl, input st_t st, input logic [3:0] ack,
                       input logic [1:0] vidx, input logic [2:0] nest);
        vec_t v;
        v.tag = tag; v.rst_n = r; v.req = req; v.omf = omf; v.stl = stl;
        v.fv = rti; v.op = rti ? 5'b11110 : 5'b00000;
        v.ack = ack; v.vidx = vidx; v.nest = nest;
        v.iv = 1'b1; v.fh = 1'b1; v.busy = 1'b1;
        case (st)
            S_IDLE: begin v.iv = 1'b0; v.iop = 5'b00000; v.fh = 1'b0; v.busy = 1'b0; end
            S_WT:   begin v.iv = 1'b0; v.iop = 5'b00000; end
            S_PH:   v.iop = 5'b10110;
            S_PL:   v.iop = 5'b10101;
            S_PF:   v.iop = 5'b11111;
            S_POPL: begin v.iop = 5'b10111; v.fh = 1'b0; end
            default: v.iop = 5'b01111;
        endcase
        tbl.push_back(v);
    endtask

    // Cycle where the RTI pops nest from n back to n-1 (caller supplies vector index).
    task automatic add_rti(input string tag, input logic [1:0] vi, input logic [2:0] n);
        add(tag, 1, 4'b0000, 1, 0, 0, S_IDLE, 4'b0000, vi, n);
        add(tag, 1, 4'b0000, 0, 0, 0, S_POPL, 4'b0000, vi, n);
        add(tag, 1, 4'b0000, 0, 0, 0, S_POPF, 4'b0000, vi, n);
        add(tag, 1, 4'b0000, 0, 0, 0, S_IDLE, 4'b0000, vi, (n == 3'd0) ? 3'd0 : n - 3'd1);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            vec_t e;
            e = sb.pop_front();
            n_tests++;
            if ({inject_valid, inject_op, fetch_hold, int_ack, vector_idx, nest_cnt, busy} !==
                {e.iv, e.iop, e.fh, e.ack, e.vidx, e.nest, e.busy}) begin
                n_fail++;
                $display("FAIL %s t=%0t: got iv=%b op=%b fh=%b ack=%b idx=%0d nest=%0d busy=%b, want iv=%b op=%b fh=%b ack=%b idx=%0d nest=%0d busy=%b",
                         e.tag, $time, inject_valid, inject_op, fetch_hold, int_ack, vector_idx,
                         nest_cnt, busy, e.iv, e.iop, e.fh, e.ack, e.vidx, e.nest, e.busy);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; int_req = '0; fetched_op = '0; fetch_valid = 1'b0;
        one_more_fetch = 1'b0; stall = 1'b0;

        add("reset", 0, 4'b0000, 0, 0, 0, S_IDLE, 4'b0000, 0, 0);
        add("reset", 0, 4'b0000, 0, 0, 0, S_IDLE, 4'b0000, 0, 0);
        add("idle",  1, 4'b0000, 0, 0, 0, S_IDLE, 4'b0000, 0, 0);

        add("single", 1, 4'b0001, 0, 0, 0, S_IDLE, 4'b0000, 0, 0);
        add("single", 1, 4'b0000, 0, 0, 0, S_IDLE, 4'b0000, 0, 0);
        add("single", 1, 4'b0000, 0, 0, 0, S_WT,   4'b0000, 0, 0);
        add("single", 1, 4'b0000, 0, 0, 0, S_PH,   4'b0000, 0, 0);
        add("single", 1, 4'b0000, 0, 0, 0, S_PL,   4'b0000, 0, 0);
        add("single", 1, 4'b0000, 0, 0, 0, S_PF,   4'b0001, 0, 0);
        add("single", 1, 4'b0000, 0, 0, 0, S_IDLE, 4'b0000, 0, 1);

        add_rti("rti_1to0", 0, 1);

        // Channel 0 already pending when RTI is fetched at depth 0: RTI goes first, depth stays 0.
        add("rti_vs_int", 1, 4'b0001, 0, 0, 0, S_IDLE, 4'b0000, 0, 0);
        add("rti_vs_int", 1, 4'b0000, 1, 0, 0, S_IDLE, 4'b0000, 0, 0);
        add("rti_vs_int", 1, 4'b0000, 0, 0, 0, S_POPL, 4'b0000, 0, 0);
        add("rti_vs_int", 1, 4'b0000, 0, 0, 0, S_POPF, 4'b0000, 0, 0);
        add("rti_vs_int", 1, 4'b0000, 0, 0, 0, S_IDLE, 4'b0000, 0, 0);
        add("rti_vs_int", 1, 4'b0000, 0, 0, 0, S_WT,   4'b0000, 0, 0);
        add("rti_vs_int", 1, 4'b0000, 0, 0, 0, S_PH,   4'b0000, 0, 0);
        add("rti_vs_int", 1, 4'b0000, 0, 0, 0, S_PL,   4'b0000, 0, 0);
        add("rti_vs_int", 1, 4'b0000, 0, 0, 0, S_PF,   4'b0001, 0, 0);
        add("rti_vs_int", 1, 4'b0000, 0, 0, 0, S_IDLE, 4'b0000, 0, 1);
        add_rti("rti_clear", 0, 1);

        add("stall", 1, 4'b0100, 0, 0, 0, S_IDLE, 4'b0000, 0, 0);
        add("stall", 1, 4'b0000, 0, 0, 0, S_IDLE, 4'b0000, 0, 0);
        add("stall", 1, 4'b0000, 0, 0, 0, S_WT,   4'b0000, 2, 0);
        add("stall", 1, 4'b0000, 0, 0, 0, S_PH,   4'b0000, 2, 0);
        add("stall", 1, 4'b0000, 0, 0, 1, S_PL,   4'b0000, 2, 0);
        add("stall", 1, 4'b0001, 0, 0, 1, S_PL,   4'b0000, 2, 0);
        add("stall", 1, 4'b0000, 0, 0, 1, S_PL,   4'b0000, 2, 0);
        add("stall", 1, 4'b0000, 0, 0, 0, S_PL,   4'b0000, 2, 0);
        add("stall_ack", 1, 4'b0000, 0, 0, 1, S_PF, 4'b0000, 2, 0);
        add("stall_ack", 1, 4'b0000, 0, 0, 0, S_PF, 4'b0100, 2, 0);
        add("stall_rti", 1, 4'b0000, 1, 0, 0, S_IDLE, 4'b0000, 2, 1);
        add("stall_rti", 1, 4'b0000, 0, 0, 0, S_POPL, 4'b0000, 2, 1);
        add("stall_rti", 1, 4'b0000, 0, 0, 0, S_POPF, 4'b0000, 2, 1);
        add("stall_rti", 1, 4'b0000, 0, 0, 0, S_IDLE, 4'b0000, 2, 0);
        add("mid_reset", 1, 4'b0000, 0, 0, 0, S_WT,   4'b0000, 0, 0);
        add("mid_reset", 1, 4'b0000, 0, 0, 0, S_PH,   4'b0000, 0, 0);
        add("mid_reset", 1, 4'b0000, 0, 0, 0, S_PL,   4'b0000, 0, 0);
        add("mid_reset", 1, 4'b0010, 0, 0, 1, S_PF,   4'b0000, 0, 0);
        add("mid_reset", 0, 4'b0000, 0, 0, 0, S_IDLE, 4'b0000, 0, 0);
        add("post_reset", 1, 4'b0000, 0, 0, 0, S_IDLE, 4'b0000, 0, 0);
        add("post_reset", 1, 4'b0000, 0, 0, 0, S_IDLE, 4'b0000, 0, 0);
        add("post_reset", 1, 4'b0000, 0, 0, 0, S_IDLE, 4'b0000, 0, 0);

`ifdef INT_NEST_EN
        add("nest", 1, 4'b0111, 0, 0, 0, S_IDLE, 4'b0000, 0, 0);
        add("nest", 1, 4'b0000, 0, 0, 0, S_IDLE, 4'b0000, 0, 0);
        add("nest", 1, 4'b0000, 0, 0, 0, S_WT,   4'b0000, 0, 0);
        add("nest", 1, 4'b0000, 0, 0, 0, S_PH,   4'b0000, 0, 0);
        add("nest", 1, 4'b0000, 0, 0, 0, S_PL,   4'b0000, 0, 0);
        add("nest", 1, 4'b0000, 0, 0, 0, S_PF,   4'b0001, 0, 0);
        add("nest", 1, 4'b0000, 0, 0, 0, S_IDLE, 4'b0000, 0, 1);
        add("nest", 1, 4'b0000, 0, 0, 0, S_WT,   4'b0000, 1, 1);
        add("nest", 1, 4'b0000, 0, 0, 0, S_PH,   4'b0000, 1, 1);
        add("nest", 1, 4'b0000, 0, 0, 0, S_PL,   4'b0000, 1, 1);
        add("nest", 1, 4'b0000, 0, 0, 0, S_PF,   4'b0010, 1, 1);
        add("nest", 1, 4'b0000, 0, 0, 0, S_IDLE, 4'b0000, 1, 2);
        add_rti("nest_full", 1, 2);
        add("nest", 1, 4'b0000, 0, 0, 0, S_WT,   4'b0000, 2, 1);
        add("nest", 1, 4'b0000, 0, 0, 0, S_PH,   4'b0000, 2, 1);
        add("nest", 1, 4'b0000, 0, 0, 0, S_PL,   4'b0000, 2, 1);
        add("nest", 1, 4'b0000, 0, 0, 0, S_PF,   4'b0100, 2, 1);
        add("nest", 1, 4'b0000, 0, 0, 0, S_IDLE, 4'b0000, 2, 2);
`else
        add("prio_ldm", 1, 4'b1010, 0, 0, 0, S_IDLE, 4'b0000, 0, 0);
        add("prio_ldm", 1, 4'b0000, 0, 1, 0, S_IDLE, 4'b0000, 0, 0);
        add("prio_ldm", 1, 4'b0000, 0, 0, 0, S_WT,   4'b0000, 1, 0);
        add("prio_ldm", 1, 4'b0000, 0, 0, 0, S_WT,   4'b0000, 1, 0);
        add("prio_ldm", 1, 4'b0000, 0, 0, 0, S_PH,   4'b0000, 1, 0);
        add("prio_ldm", 1, 4'b0000, 0, 0, 0, S_PL,   4'b0000, 1, 0);
        add("prio_ldm", 1, 4'b0000, 0, 0, 0, S_PF,   4'b0010, 1, 0);
        add("blocked",  1, 4'b0000, 0, 0, 0, S_IDLE, 4'b0000, 1, 1);
        add_rti("blocked_rti", 1, 1);
        add("ch3", 1, 4'b0000, 0, 0, 0, S_WT,   4'b0000, 3, 0);
        add("ch3", 1, 4'b0000, 0, 0, 0, S_PH,   4'b0000, 3, 0);
        add("ch3", 1, 4'b0000, 0, 0, 0, S_PL,   4'b0000, 3, 0);
        add("ch3", 1, 4'b0000, 0, 0, 0, S_PF,   4'b1000, 3, 0);
        add("ch3", 1, 4'b0000, 0, 0, 0, S_IDLE, 4'b0000, 3, 1);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            reset_n        = tbl[i].rst_n;
            int_req        = tbl[i].req;
            fetch_valid    = tbl[i].fv;
            fetched_op     = tbl[i].op;
            one_more_fetch = tbl[i].omf;
            stall          = tbl[i].stl;
            sb.push_back(tbl[i]);
        end

        for (int k = 0; k < 4; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/int_sequencer.md
# int_sequencer

Parametrised interrupt sequencer for the five-stage pipeline. It sits beside the decode-stage control unit. It latches up to NUM_INT interrupt requests and resolves priority. It waits for a safe instruction boundary, then injects the special opcodes push_pc_high, push_pc_low and push_flags into the decode slot. On RTI it injects pop_pc_low and pop_flags. Unlike the single-input negedge INT counter it replaces, it is fully posedge, multi-channel, stall-aware, and tracks nesting depth.

## Interface
- N, 5, opcode width
- NUM_INT, 4, number of interrupt request lines (1..16)
- MAX_NEST, 3, maximum nesting depth tracked (1..7)
- clk  input  1  pipeline clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- int_req  input  NUM_INT  level/pulse requests, sampled each rising edge
- fetched_op  input  N  opcode currently in fetch/decode buffer
- fetch_valid  input  1  fetched_op is a real instruction
- one_more_fetch  input  1  current instruction needs one more fetch (LDM immediate)
- stall  input  1  pipeline stall; sequencer freezes
- inject_valid  output  1  inject_op replaces decode opcode this cycle
- inject_op  output  N  injected special opcode
- fetch_hold  output  1  PC must not advance
- int_ack  output  NUM_INT  one-hot, one-cycle acknowledge
- vector_idx  output  clog2(NUM_INT) (min 1)  index of the serviced channel
- nest_cnt  output  3  current nesting depth
- busy  output  1  state != IDLE

## Operation
- Opcodes: push_pc_high=10110, push_pc_low=10101, push_flags=11111, pop_pc_low=10111, pop_flags=01111, RTI=11110.
- pending[i] is set on int_req[i]=1 and stays set until int_ack[i]. A request re-asserted during its own ack cycle is lost.
- Priority: lowest index wins. Arbitration happens only in IDLE.
- Eligibility without nesting: any pending bit and nest_cnt==0.
- States: IDLE, WAIT_BND, PUSH_H, PUSH_L, PUSH_F, POP_L, POP_F.
- IDLE:
  - fetch_valid & fetched_op==RTI -> POP_L. RTI wins over a simultaneous eligible interrupt.
  - Otherwise an eligible interrupt -> WAIT_BND. Latch vector_idx. Load wait bit = one_more_fetch.
- WAIT_BND: fetch_hold=1. If the wait bit is set, clear it and stay; otherwise -> PUSH_H.
- PUSH_H -> PUSH_L -> PUSH_F -> IDLE. Each state drives inject_valid=1, inject_op=its code, fetch_hold=1.
- PUSH_F: int_ack[vector_idx]=1, clear pending[vector_idx], nest_cnt+1 (saturating at MAX_NEST).
- POP_L -> POP_F -> IDLE, injecting pop_pc_low then pop_flags. nest_cnt-1 in POP_F, saturating at 0. fetch_hold=0 in POP_L; fetch_hold=1 in POP_F.
- RTI with nest_cnt==0 still runs the pop sequence; the count stays 0.
- Outside inject states: inject_op=00000 (NOP), inject_valid=0.

## Timing
- Reset (async assert, sync release): state=IDLE, pending=0, nest_cnt=0, vector_idx=0, wait bit=0. Every output is 0.
- All outputs are registered, decoded from state.
- Latency, request to first injection: request at edge k gives WAIT_BND at k+1 and PUSH_H at k+2. Add +1 if one_more_fetch was high.
- Request to int_ack: 4 cycles (5 with one_more_fetch). Total entry length: 4 or 5 cycles.
- stall=1: state, wait bit and nest_cnt hold. Outputs stay at their current values, except int_ack is forced 0 and reasserted when the stall releases. Pending bits still accumulate.
- Requests arriving in any non-IDLE state only set pending. They are arbitrated on return to IDLE.
- A reset mid-sequence aborts immediately, with no partial ack.

## Configuration
- INT_NEST_EN
  - Defined: eligibility becomes nest_cnt < MAX_NEST (nested entry allowed).
  - Undefined: eligibility requires nest_cnt==0, and nest_cnt never exceeds 1. MAX_NEST is ignored.

## Test plan
- Single request: int_req=0001 pulse, one_more_fetch=0 -> inject 10110, 10101, 11111 in cycles 2-4; int_ack=0001 in cycle 4; vector_idx=0; nest_cnt=1.
- Priority: int_req=1010 in the same cycle -> channel 1 serviced first (ack=0010); channel 3 stays pending.
- LDM boundary: one_more_fetch=1 at entry -> WAIT_BND lasts 2 cycles; push_pc_high appears in cycle 3.
- RTI vs interrupt: fetched_op=11110 with int_req=0001 in IDLE -> POP_L (10111), POP_F (01111), nest_cnt 1->0, then the entry sequence for channel 0.
- Stall and reset: stall=1 for 3 cycles in PUSH_L -> inject_op holds 10101, no ack. reset_n=0 in PUSH_F -> all outputs 0, pending cleared.
- Nesting: with INT_NEST_EN, MAX_NEST=2, three requests in sequence -> nest_cnt 1, 2, and the third stays pending until an RTI. Without the macro, the second request waits for an RTI.
